// File: rtl/ctrl_pipe.sv
// Registered control decoder: one instruction per cycle, load stall sequencing,
// branch squash and sticky program-done. Optional LFSR tap select under CTRL_TAP_EN.
module ctrl_pipe #(
  parameter int IW       = 9,
  parameter int TW       = 6,
  parameter int RW       = 3,
  parameter int AW       = 8,
  parameter int MEM_LAT  = 1,
  parameter int TAP_ADDR = 62
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IW-1:0] i_instruction,
  input  logic          i_inst_valid,
  input  logic [AW-1:0] i_dat_mem_addr,
  input  logic          i_branch_flag,
  output logic          o_branch,
  output logic          o_branch_en,
  output logic          o_taken,
  output logic          o_reg_wr_en,
  output logic          o_mem_wr_en,
  output logic          o_load_inst,
  output logic          o_immediate,
  output logic          o_tap_sel,
  output logic          o_stall,
  output logic          o_ack,
  output logic [TW-1:0] o_pc_targ,
  output logic [RW-1:0] o_reg_write_index
);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH     = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [1:0]    r_state;
  logic [2:0]    r_cnt;
  logic          r_branch, r_branch_en, r_taken, r_reg_wr_en, r_mem_wr_en;
  logic          r_load_inst, r_immediate, r_stall, r_ack;
  logic [TW-1:0] r_pc_targ;
  logic [RW-1:0] r_reg_write_index;

  logic [1:0]    w_state_next;
  logic [2:0]    w_cnt_next;
  logic          w_branch_next, w_branch_en_next, w_taken_next, w_reg_wr_en_next;
  logic          w_mem_wr_en_next, w_load_inst_next, w_immediate_next;
  logic          w_stall_next, w_ack_next;
  logic [TW-1:0] w_pc_targ_next;
  logic [RW-1:0] w_reg_write_index_next;
  logic [2:0]    w_opclass;

  assign w_opclass = i_instruction[IW-2:IW-4];

  always_comb begin
    w_state_next           = r_state;
    w_cnt_next             = r_cnt;
    w_branch_next          = 1'b0;
    w_branch_en_next       = 1'b0;
    w_taken_next           = 1'b0;
    w_reg_wr_en_next       = 1'b0;
    w_mem_wr_en_next       = 1'b0;
    w_load_inst_next       = 1'b0;
    w_immediate_next       = 1'b0;
    w_stall_next           = 1'b0;
    w_ack_next             = 1'b0;
    w_pc_targ_next         = '0;
    w_reg_write_index_next = '0;

    case (r_state)
      S_RUN: begin
        if (i_inst_valid) begin
          w_reg_write_index_next = i_instruction[1] ? i_instruction[RW+1:2] : '0;
          if (&i_instruction) begin
            w_ack_next             = 1'b1;
            w_reg_write_index_next = '0;
            w_state_next           = S_DONE;
          end else if (i_instruction[0]) begin
            w_immediate_next = 1'b1;
            w_reg_wr_en_next = 1'b1;
          end else if (i_instruction[IW-1]) begin
            w_branch_next    = i_instruction[IW-2];
            w_branch_en_next = !i_instruction[IW-2];
            w_pc_targ_next   = i_instruction[TW:1];
            w_taken_next     = i_instruction[IW-2] | i_branch_flag;
            if (w_taken_next) w_state_next = S_FLUSH;
          end else begin
            case (w_opclass)
              3'b000: w_mem_wr_en_next = 1'b1;
              3'b001: begin
                w_load_inst_next = 1'b1;
                if (LAT != 3'd0) begin
                  w_stall_next = 1'b1;
                  w_cnt_next   = LAT;
                  w_state_next = S_LOAD_WAIT;
                end else begin
                  w_reg_wr_en_next = 1'b1;
                end
              end
              3'b101:  w_reg_wr_en_next = i_instruction[1];
              default: w_reg_wr_en_next = 1'b1;
            endcase
          end
        end
      end
      S_LOAD_WAIT: begin
        // Hold the load's destination so the late write lands on the right register.
        w_reg_write_index_next = r_reg_write_index;
        w_load_inst_next       = 1'b1;
        w_cnt_next             = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_reg_wr_en_next = 1'b1;
          w_state_next     = S_RUN;
        end else begin
          w_stall_next = 1'b1;
        end
      end
      S_FLUSH: w_state_next = S_RUN;
      S_DONE:  w_ack_next   = 1'b1;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= S_RUN;
      r_cnt             <= '0;
      r_branch          <= 1'b0;
      r_branch_en       <= 1'b0;
      r_taken           <= 1'b0;
      r_reg_wr_en       <= 1'b0;
      r_mem_wr_en       <= 1'b0;
      r_load_inst       <= 1'b0;
      r_immediate       <= 1'b0;
      r_stall           <= 1'b0;
      r_ack             <= 1'b0;
      r_pc_targ         <= '0;
      r_reg_write_index <= '0;
    end else begin
      r_state           <= w_state_next;
      r_cnt             <= w_cnt_next;
      r_branch          <= w_branch_next;
      r_branch_en       <= w_branch_en_next;
      r_taken           <= w_taken_next;
      r_reg_wr_en       <= w_reg_wr_en_next;
      r_mem_wr_en       <= w_mem_wr_en_next;
      r_load_inst       <= w_load_inst_next;
      r_immediate       <= w_immediate_next;
      r_stall           <= w_stall_next;
      r_ack             <= w_ack_next;
      r_pc_targ         <= w_pc_targ_next;
      r_reg_write_index <= w_reg_write_index_next;
    end
  end

`ifdef CTRL_TAP_EN
  logic [AW-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_addr <= '0;
    else          r_addr <= i_dat_mem_addr;
  end

  assign o_tap_sel = r_load_inst & (r_addr == AW'(TAP_ADDR));
`else
  logic w_unused_tap;
  assign w_unused_tap = ^{i_dat_mem_addr, AW'(TAP_ADDR)};
  assign o_tap_sel    = 1'b0;
`endif

  assign o_branch          = r_branch;
  assign o_branch_en       = r_branch_en;
  assign o_taken           = r_taken;
  assign o_reg_wr_en       = r_reg_wr_en;
  assign o_mem_wr_en       = r_mem_wr_en;
  assign o_load_inst       = r_load_inst;
  assign o_immediate       = r_immediate;
  assign o_stall           = r_stall;
  assign o_ack             = r_ack;
  assign o_pc_targ         = r_pc_targ;
  assign o_reg_write_index = r_reg_write_index;

endmodule
